// File: rtl/fifo_credit_tx.sv
// Credit-based push generator: accepts upstream valid/ready words and issues
// registered push strobes into a DEPTH-entry FIFO, spending one credit per push.
module fifo_credit_tx #(
  parameter  int DEPTH = 8,
  parameter  int DW    = 32,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          push,
  output logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          err_clr,
  output logic [CW-1:0] credits,
  output logic          stalled,
  output logic          credit_err
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e        state_q,      state_d;
  logic [CW-1:0] credits_q,    credits_d;
  logic          push_q,       push_d;
  logic [DW-1:0] push_data_q,  push_data_d;
  logic          stalled_q,    stalled_d;
  logic          credit_err_q, credit_err_d;

  logic active;
  logic full_credit;
  logic accept;
  logic pop_ok;
  logic err_set;

  // Pops are only honoured once out of INIT; a pop with every credit already
  // home is an overflow unless an accept spends one in the same cycle.
  assign active      = (state_q != ST_INIT);
  assign full_credit = (credits_q == DEPTH_C);
  assign in_ready    = (state_q == ST_RUN) && (credits_q != '0);
  assign accept      = in_valid && in_ready;
  assign pop_ok      = active && pop && (!full_credit || accept);
  assign err_set     = active && pop && full_credit && !accept;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    credits_d    = credits_q;
    push_d       = accept;
    push_data_d  = accept ? in_data : push_data_q;
    credit_err_d = err_set | (credit_err_q & ~err_clr);

    unique case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN, ST_STALL: begin
        credits_d = credits_q - CW'(accept) + CW'(pop_ok);
        state_d   = (credits_d == '0) ? ST_STALL : ST_RUN;
      end
      default: state_d = ST_INIT;
    endcase

    stalled_d = (state_d == ST_STALL);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      credits_q    <= DEPTH_C;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      stalled_q    <= 1'b0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      stalled_q    <= stalled_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign push       = push_q;
  assign push_data  = push_data_q;
  assign credits    = credits_q;
  assign stalled    = stalled_q;
  assign credit_err = credit_err_q;

  // Credits never leave 0..DEPTH, and a word is never offered a slot it lacks.
  a_credit_range : assert property (@(posedge clk) disable iff (!rst_n)
    credits_q <= DEPTH_C);
  a_ready_has_credit : assert property (@(posedge clk) disable iff (!rst_n)
    in_ready |-> (credits_q != '0));
  a_stall_means_empty : assert property (@(posedge clk) disable iff (!rst_n)
    stalled_q |-> (credits_q == '0));

endmodule

// File: tb/tb_fifo_credit_tx.sv
// Directed bench for fifo_credit_tx: a credit-count model checked every cycle,
// plus hand-computed literal expectations along the directed scenarios.
module tb_fifo_credit_tx;

  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          pop      = 1'b0;
  logic          err_clr  = 1'b0;
  logic          in_ready;
  logic          push;
  logic [DW-1:0] push_data;
  logic [CW-1:0] credits;
  logic          stalled;
  logic          credit_err;

  fifo_credit_tx #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .err_clr    (err_clr),
    .credits    (credits),
    .stalled    (stalled),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_bad  = 0;
  int n_push = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: free slots as a plain integer; the block accepts only once it has
  // seen one edge out of reset and while at least one slot is free.
  int            m_credits = DEPTH;
  bit            m_running = 1'b0;
  bit            m_push    = 1'b0;
  bit            m_err     = 1'b0;
  logic [DW-1:0] m_data    = '0;

  function automatic bit exp_ready();
    return m_running && (m_credits > 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit acc;
    int nxt;
    if (!rst_n) begin
      m_credits <= DEPTH;
      m_running <= 1'b0;
      m_push    <= 1'b0;
      m_data    <= '0;
      m_err     <= 1'b0;
    end else if (!m_running) begin
      m_running <= 1'b1;
      m_push    <= 1'b0;
      if (err_clr) m_err <= 1'b0;
    end else begin
      acc = in_valid && exp_ready();
      nxt = m_credits - int'(acc) + int'(pop);
      if (nxt > DEPTH) nxt = DEPTH;
      m_credits <= nxt;
      m_push    <= acc;
      if (acc) m_data <= in_data;
      if (pop && (m_credits == DEPTH) && !acc) m_err <= 1'b1;
      else if (err_clr)                        m_err <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("m_in_ready",   in_ready,   exp_ready());
    check("m_push",       push,       m_push);
    check("m_push_data",  push_data,  m_data);
    check("m_credits",    credits,    m_credits);
    check("m_stalled",    stalled,    m_running && (m_credits == 0));
    check("m_credit_err", credit_err, m_err);
    if (push === 1'b1) n_push++;
  end

  // Apply inputs for the current cycle, then move 1 time unit past the next edge.
  task automatic drive(input bit v, input logic [DW-1:0] d, input bit p, input bit c);
    in_valid = v;
    in_data  = d;
    pop      = p;
    err_clr  = c;
    @(posedge clk);
    #1;
  endtask

  int base;

  initial begin
    in_valid = 1'b1;
    in_data  = 32'hA000_0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset release: INIT cycle, then ready, then first push
    check("t1_init_ready", in_ready, 1'b0);
    drive(1'b1, 32'hA000_0000, 1'b0, 1'b0);
    check("t1_ready",    in_ready, 1'b1);
    check("t1_credits8", credits,  8);
    check("t1_no_push",  push,     1'b0);
    drive(1'b1, 32'hA000_0000, 1'b0, 1'b0);
    check("t1_push",     push,      1'b1);
    check("t1_data",     push_data, 32'hA000_0000);
    check("t1_credits7", credits,   7);

    // Stream until credits run out
    for (int i = 1; i < 8; i++) drive(1'b1, 32'hA000_0000 + i, 1'b0, 1'b0);
    check("t2_credits0", credits,   0);
    check("t2_stalled",  stalled,   1'b1);
    check("t2_ready0",   in_ready,  1'b0);
    check("t2_push8",    push,      1'b1);
    check("t2_data8",    push_data, 32'hA000_0007);
    drive(1'b1, 32'hBEEF_0008, 1'b0, 1'b0);
    check("t2_no_9th",   push,      1'b0);
    check("t2_held0",    credits,   0);
    check("t2_count",    n_push,    8);

    // Single pop from empty credits
    drive(1'b1, 32'hBEEF_0008, 1'b1, 1'b0);
    check("t3_credits1", credits,  1);
    check("t3_unstall",  stalled,  1'b0);
    check("t3_ready",    in_ready, 1'b1);
    check("t3_no_push",  push,     1'b0);
    drive(1'b1, 32'hBEEF_0008, 1'b0, 1'b0);
    check("t3_push",     push,      1'b1);
    check("t3_data",     push_data, 32'hBEEF_0008);
    check("t3_credits0", credits,   0);
    check("t3_stalled",  stalled,   1'b1);

    // Simultaneous accept and pop at credits=3
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);
    check("t4_credits3", credits, 3);
    base = n_push;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'hC000_0000 + i, 1'b1, 1'b0);
      check("t4_steady", credits, 3);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    check("t4_pushes",   n_push - base, 10);
    check("t4_hold",     push_data,     32'hC000_0009);
    check("t4_idle",     push,          1'b0);

    // Credit overflow and sticky error
    repeat (5) drive(1'b0, '0, 1'b1, 1'b0);
    check("t5_credits8", credits,    8);
    check("t5_no_err",   credit_err, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    check("t5_err",      credit_err, 1'b1);
    check("t5_saturate", credits,    8);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("t5_sticky",   credit_err, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("t5_clr",      credit_err, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b1);
    check("t5_set_wins", credit_err, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("t5_clr2",     credit_err, 1'b0);

    // Async reset mid-stream
    for (int i = 0; i < 6; i++) drive(1'b1, 32'hD000_0000 + i, 1'b0, 1'b0);
    check("t6_credits2", credits, 2);
    check("t6_push",     push,    1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_push",    push,     1'b0);
    check("t6_rst_credits", credits,  8);
    check("t6_rst_ready",   in_ready, 1'b0);
    check("t6_rst_stalled", stalled,  1'b0);
    drive(1'b1, 32'hE000_0000, 1'b0, 1'b0);
    drive(1'b1, 32'hE000_0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    pop   = 1'b1;
    check("t6_init_ready", in_ready, 1'b0);
    drive(1'b1, 32'hE000_0000, 1'b1, 1'b0);
    check("t6_init_pop",   credits,    8);
    check("t6_init_err",   credit_err, 1'b0);
    check("t6_run_ready",  in_ready,   1'b1);
    drive(1'b1, 32'hE000_0000, 1'b0, 1'b0);
    check("t6_push",       push,      1'b1);
    check("t6_data",       push_data, 32'hE000_0000);
    check("t6_credits7",   credits,   7);

    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
